alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Initiator side of the 32-bit ALU interface. It accepts R-type requests (funct, operand A, operand B) over a valid/ready handshake.
- Decodes funct into the 3-bit ALU op, drives registered operands and op to the combinational ALU, waits a programmable settle time, then captures the ALU result and zero flag.
- Returns the captured result with overflow and error status over a second valid/ready handshake.
- Sits between the control path and the datapath ALU.

Parameters:
- SETTLE, 1, cycles the ALU inputs are held before capture (legal range 1..15)
- CNT_W, 16, width of the completed-operation counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_funct  input  6  R-type funct code
- req_a  input  32  operand A
- req_b  input  32  operand B
- alu_a  output  32  registered operand A to ALU
- alu_b  output  32  registered operand B to ALU
- alu_op  output  3  registered ALU op (bit 2 = subtract/carry-in, bits 1:0 = result select)
- alu_z  input  32  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_ex  input  1  ALU zero flag (1 when alu_z == 0)
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_data  output  32  captured result
- resp_zero  output  1  captured zero flag
- resp_ovf  output  1  signed overflow (add/sub only)
- resp_err  output  1  illegal funct
- op_count  output  CNT_W  number of completed legal operations, saturating

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0, except req_ready = 1 once reset releases. Internal settle counter 0.
- Reset asserted mid-operation aborts the operation: no response is issued and op_count is not incremented.
- Decode:
  - 0x24 AND -> 000
  - 0x25 OR -> 001
  - 0x20 ADD -> 010
  - 0x22 SUB -> 110
  - 0x2A SLT -> 111
  - any other code is illegal.
- State IDLE:
  - req_ready = 1.
  - On req_valid & req_ready with a legal funct: load alu_a, alu_b and alu_op at that edge, clear the counter, go to EXEC.
  - On an illegal funct: alu_a/alu_b/alu_op are unchanged; load resp_data = 0, resp_zero = 0, resp_ovf = 0, resp_err = 1; go to RESP.
- State EXEC:
  - req_ready = 0 and the alu_* outputs are held stable.
  - The counter increments each cycle.
  - On the edge where counter == SETTLE-1: capture resp_data = alu_z, resp_zero = alu_ex, resp_err = 0 and resp_ovf; increment op_count unless it is at all-ones; go to RESP.
  - resp_valid therefore rises SETTLE cycles after the acceptance edge.
- Overflow, computed from the registered operands and alu_z:
  - ADD: alu_a[31] == alu_b[31] and alu_z[31] != alu_a[31].
  - SUB: alu_a[31] != alu_b[31] and alu_z[31] != alu_a[31].
  - AND, OR, SLT: 0.
- State RESP:
  - resp_valid = 1 and the resp_* outputs are held stable, with any resp_ready stall length honoured.
  - On resp_ready: go to IDLE. resp_valid drops the next cycle; resp_* values persist until the next capture.
- No request is accepted in the cycle resp_ready is taken. Minimum issue interval is SETTLE + 2 cycles.
- req_* inputs are ignored outside IDLE. A request that is held across the busy window is taken on the first IDLE cycle.
- op_count saturates at 2^CNT_W - 1; it does not wrap.
- Error responses do not count.

Test Plan:
- ADD 5 + 7 (funct 0x20), resp_ready = 1 -> alu_op = 010, resp_data = 12, zero = 0, ovf = 0, err = 0, resp_valid 1 cycle after acceptance (SETTLE = 1), op_count = 1.
- SUB 5 - 5 (0x22) -> alu_op = 110, resp_data = 0, resp_zero = 1; then SLT -3 vs 2 (0x2A) -> resp_data = 1.
- ADD 0x7FFFFFFF + 1 -> resp_data = 0x80000000, ovf = 1; SUB 0x80000000 - 1 -> resp_data = 0x7FFFFFFF, ovf = 1.
- Illegal funct 0x18 after a prior legal op -> err = 1, resp_data = 0, alu_op unchanged from the prior op, op_count unchanged.
- Backpressure: hold resp_ready = 0 for 5 cycles with req_valid held high -> resp stable, req_ready = 0 throughout; the second request is accepted on the first IDLE cycle after the handshake.
- Reset: pull rst_n low during EXEC -> all outputs 0 immediately, no resp_valid after release. With SETTLE = 3, latency is 3 cycles.

Source files
------------

// File: rtl/alu_issue_unit.sv
// -----------------------------------------------------------------------------
// alu_issue_unit
//   Initiator side of the 32-bit ALU interface. Accepts R-type requests
//   (funct, A, B) on a valid/ready handshake, decodes funct into the 3-bit
//   ALU op, drives registered operands/op to an external combinational ALU,
//   holds them for SETTLE cycles, captures result and zero flag, and returns
//   them with signed-overflow and illegal-funct status on a second
//   valid/ready handshake.
//
// Parameters
//   SETTLE : cycles the ALU inputs are held before capture (1..15)
//   CNT_W  : width of the saturating completed-operation counter
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req_valid/req_ready         : request handshake
//   req_funct, req_a, req_b     : R-type funct code and operands
//   alu_a, alu_b, alu_op        : registered ALU inputs
//   alu_z, alu_ex               : ALU result and zero flag
//   resp_valid/resp_ready       : response handshake
//   resp_data, resp_zero,
//   resp_ovf, resp_err          : captured result and status
//   op_count                    : completed legal operations (saturating)
// -----------------------------------------------------------------------------
module alu_issue_unit #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_op,
  input  logic [31:0]      alu_z,
  input  logic             alu_ex,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_zero,
  output logic             resp_ovf,
  output logic             resp_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  // Returns {legal, op}; op bit 2 selects subtract, bits 1:0 the result mux.
  function automatic logic [3:0] decode_funct(input logic [5:0] funct);
    logic [3:0] r;
    case (funct)
      6'h24:   r = 4'b1_000;  // AND
      6'h25:   r = 4'b1_001;  // OR
      6'h20:   r = 4'b1_010;  // ADD
      6'h22:   r = 4'b1_110;  // SUB
      6'h2A:   r = 4'b1_111;  // SLT
      default: r = 4'b0_000;
    endcase
    return r;
  endfunction

  // Signed overflow from operand and result sign bits; only add/sub can overflow.
  function automatic logic calc_ovf(input logic [2:0] op, input logic a31,
                                    input logic b31, input logic z31);
    logic r;
    case (op)
      3'b010:  r = (a31 == b31) && (z31 != a31);
      3'b110:  r = (a31 != b31) && (z31 != a31);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t           state_r;
  logic [3:0]       cnt_r;
  logic [31:0]      alu_a_r;
  logic [31:0]      alu_b_r;
  logic [2:0]       alu_op_r;
  logic             resp_valid_r;
  logic [31:0]      resp_data_r;
  logic             resp_zero_r;
  logic             resp_ovf_r;
  logic             resp_err_r;
  logic [CNT_W-1:0] op_count_r;

  logic [3:0]       dec_s;
  logic             legal_s;
  logic [2:0]       op_s;
  logic             ovf_s;

  // Decode the incoming funct and evaluate overflow on the held ALU inputs.
  always_comb begin
    dec_s   = decode_funct(req_funct);
    legal_s = dec_s[3];
    op_s    = dec_s[2:0];
    ovf_s   = calc_ovf(alu_op_r, alu_a_r[31], alu_b_r[31], alu_z[31]);
  end

  // Ready is gated by rst_n so it reads 0 while reset is held, 1 right after release.
  assign req_ready  = rst_n & (state_r == IDLE);
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_op     = alu_op_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_zero  = resp_zero_r;
  assign resp_ovf   = resp_ovf_r;
  assign resp_err   = resp_err_r;
  assign op_count   = op_count_r;

  // Issue FSM: accept, hold ALU inputs for SETTLE cycles, capture, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      alu_a_r      <= 32'd0;
      alu_b_r      <= 32'd0;
      alu_op_r     <= 3'd0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= 32'd0;
      resp_zero_r  <= 1'b0;
      resp_ovf_r   <= 1'b0;
      resp_err_r   <= 1'b0;
      op_count_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            if (legal_s) begin
              alu_a_r  <= req_a;
              alu_b_r  <= req_b;
              alu_op_r <= op_s;
              cnt_r    <= 4'd0;
              state_r  <= EXEC;
            end else begin
              // Illegal funct: leave ALU inputs untouched, answer with an error.
              resp_data_r  <= 32'd0;
              resp_zero_r  <= 1'b0;
              resp_ovf_r   <= 1'b0;
              resp_err_r   <= 1'b1;
              resp_valid_r <= 1'b1;
              state_r      <= RESP;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == SETTLE_LAST) begin
            resp_data_r  <= alu_z;
            resp_zero_r  <= alu_ex;
            resp_ovf_r   <= ovf_s;
            resp_err_r   <= 1'b0;
            resp_valid_r <= 1'b1;
            if (op_count_r != CNT_MAX) begin
              op_count_r <= op_count_r + CNT_W'(1'b1);
            end else begin
              op_count_r <= op_count_r;
            end
            state_r <= RESP;
          end else begin
            state_r <= EXEC;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            state_r      <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_unit
//   Self-checking bench for alu_issue_unit (SETTLE = 3, CNT_W = 4 so the
//   op_count saturation point is reachable). Provides a behavioural ALU on
//   the alu_* side and predicts every response from the funct rules using
//   plain arithmetic (wide signed sums for overflow).
// -----------------------------------------------------------------------------
module tb_alu_issue_unit;

  localparam int SETTLE = 3;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       req_funct;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [2:0]       alu_op;
  logic [31:0]      alu_z;
  logic             alu_ex;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic             resp_zero;
  logic             resp_ovf;
  logic             resp_err;
  logic [CNT_W-1:0] op_count;

  alu_issue_unit #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_ex(alu_ex),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_ovf(resp_ovf), .resp_err(resp_err),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural datapath ALU.
  always_comb begin
    case (alu_op)
      3'b000:  alu_z = alu_a & alu_b;
      3'b001:  alu_z = alu_a | alu_b;
      3'b010:  alu_z = alu_a + alu_b;
      3'b110:  alu_z = alu_a - alu_b;
      3'b111:  alu_z = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_z = 32'd0;
    endcase
    alu_ex = (alu_z == 32'd0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int accept_cyc = 0;

  // Reference state: last legally issued operands/op and completed-op count.
  logic [31:0] m_a  = 32'd0;
  logic [31:0] m_b  = 32'd0;
  logic [2:0]  m_op = 3'd0;
  int          m_cnt = 0;

  // Present a request and wait (bounded) for the accepting edge; optionally
  // keep req_valid high with a follow-up request afterwards.
  task automatic accept(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input logic [5:0] nf, input logic [31:0] na,
                        input logic [31:0] nb);
    int n;
    n = 0;
    req_funct = f; req_a = a; req_b = b; req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    if (hold) begin
      req_funct = nf; req_a = na; req_b = nb;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  // Called just after the accepting edge: predict, check EXEC hold, latency,
  // response fields, stall stability and the closing handshake.
  task automatic complete(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int stall);
    logic [31:0] er;
    logic [2:0]  eop;
    bit          legal, ez, eo, ee;
    longint      sa, sb, s;
    int          lat, exp_lat;
    legal = 1'b1; eo = 1'b0; er = 32'd0; eop = m_op;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      6'h24: begin er = a & b; eop = 3'b000; end
      6'h25: begin er = a | b; eop = 3'b001; end
      6'h20: begin
        s = sa + sb; er = a + b; eop = 3'b010;
        eo = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'h22: begin
        s = sa - sb; er = a - b; eop = 3'b110;
        eo = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'h2A: begin er = (sa < sb) ? 32'd1 : 32'd0; eop = 3'b111; end
      default: legal = 1'b0;
    endcase
    ez = legal && (er == 32'd0);
    ee = !legal;
    if (legal) begin
      m_a = a; m_b = b; m_op = eop;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    exp_lat = legal ? SETTLE : 0;

    @(negedge clk);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      checks++;
      if ({req_ready, alu_op, alu_a, alu_b} !== {1'b0, m_op, m_a, m_b}) begin
        errors++;
        $display("FAIL exec_hold: ready=%b op=%b a=%h b=%h required ready=0 op=%b a=%h b=%h",
                 req_ready, alu_op, alu_a, alu_b, m_op, m_a, m_b);
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency f=%h: got %0d cycles required %0d", f, lat, exp_lat);
    end
    checks++;
    if (resp_data !== er) begin
      errors++;
      $display("FAIL resp_data f=%h a=%h b=%h: got %h required %h", f, a, b, resp_data, er);
    end
    checks++;
    if ({resp_zero, resp_ovf, resp_err} !== {ez, eo, ee}) begin
      errors++;
      $display("FAIL resp_flags f=%h: zero/ovf/err got %b%b%b required %b%b%b",
               f, resp_zero, resp_ovf, resp_err, ez, eo, ee);
    end
    checks++;
    if (op_count !== CNT_W'(m_cnt)) begin
      errors++;
      $display("FAIL op_count: got %0d required %0d", op_count, m_cnt);
    end
    checks++;
    if ({alu_op, alu_a, alu_b} !== {m_op, m_a, m_b}) begin
      errors++;
      $display("FAIL alu_regs: op=%b a=%h b=%h required op=%b a=%h b=%h",
               alu_op, alu_a, alu_b, m_op, m_a, m_b);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready, resp_data, resp_zero, resp_ovf, resp_err, alu_a} !==
          {1'b1, 1'b0, er, ez, eo, ee, m_a}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: valid=%b ready=%b data=%h alu_a=%h required 1 0 %h %h",
                 i, resp_valid, req_ready, resp_data, alu_a, er, m_a);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if ({resp_valid, req_ready, resp_data} !== {1'b0, 1'b1, er}) begin
      errors++;
      $display("FAIL handshake_done: valid=%b ready=%b data=%h required 0 1 %h",
               resp_valid, req_ready, resp_data, er);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_funct = 6'd0; req_a = 32'd0; req_b = 32'd0;
    #12;
    checks++;
    if ({req_ready, resp_valid, resp_data, resp_zero, resp_ovf, resp_err, op_count,
         alu_a, alu_b, alu_op} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b data=%h cnt=%0d alu_op=%b required all 0",
               req_ready, resp_valid, resp_data, op_count, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_basic();
    accept(6'h20, 32'd5, 32'd7, 1'b0, 6'd0, 32'd0, 32'd0);
    complete(6'h20, 32'd5, 32'd7, 0);
    accept(6'h22, 32'd5, 32'd5, 1'b0, 6'd0, 32'd0, 32'd0);
    complete(6'h22, 32'd5, 32'd5, 0);
    accept(6'h2A, 32'hFFFF_FFFD, 32'd2, 1'b0, 6'd0, 32'd0, 32'd0);
    complete(6'h2A, 32'hFFFF_FFFD, 32'd2, 0);
    accept(6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 6'd0, 32'd0, 32'd0);
    complete(6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 1);
    accept(6'h25, 32'h0000_00A0, 32'h0000_000B, 1'b0, 6'd0, 32'd0, 32'd0);
    complete(6'h25, 32'h0000_00A0, 32'h0000_000B, 0);
  endtask

  task automatic test_overflow();
    accept(6'h20, 32'h7FFF_FFFF, 32'd1, 1'b0, 6'd0, 32'd0, 32'd0);
    complete(6'h20, 32'h7FFF_FFFF, 32'd1, 0);
    accept(6'h22, 32'h8000_0000, 32'd1, 1'b0, 6'd0, 32'd0, 32'd0);
    complete(6'h22, 32'h8000_0000, 32'd1, 0);
  endtask

  task automatic test_illegal();
    accept(6'h18, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 6'd0, 32'd0, 32'd0);
    complete(6'h18, 32'h1234_5678, 32'h9ABC_DEF0, 2);
  endtask

  task automatic test_back_to_back();
    int t1;
    accept(6'h20, 32'd10, 32'd20, 1'b1, 6'h22, 32'd100, 32'd1);
    t1 = accept_cyc;
    complete(6'h20, 32'd10, 32'd20, 5);
    accept(6'h22, 32'd100, 32'd1, 1'b0, 6'd0, 32'd0, 32'd0);
    checks++;
    if (accept_cyc - t1 != SETTLE + 5 + 2) begin
      errors++;
      $display("FAIL issue_interval: got %0d cycles required %0d", accept_cyc - t1, SETTLE + 7);
    end
    complete(6'h22, 32'd100, 32'd1, 0);
  endtask

  task automatic test_reset_mid_exec();
    accept(6'h25, 32'h0F00_0000, 32'h0000_00F0, 1'b0, 6'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_data, resp_zero, resp_ovf, resp_err, op_count,
         alu_a, alu_b, alu_op} !== '0) begin
      errors++;
      $display("FAIL reset_mid_exec: ready=%b valid=%b cnt=%0d alu_a=%h required all 0",
               req_ready, resp_valid, op_count, alu_a);
    end
    m_a = 32'd0; m_b = 32'd0; m_op = 3'd0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * SETTLE + 2; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready, op_count} !== {1'b0, 1'b1, CNT_W'(0)}) begin
        errors++;
        $display("FAIL abort_no_resp cycle %0d: valid=%b ready=%b cnt=%0d required 0 1 0",
                 i, resp_valid, req_ready, op_count);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]  legal_f [5] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A};
    logic [31:0] edge_v  [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    logic [5:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        f = 6'($urandom_range(0, 63));
        while (f == 6'h24 || f == 6'h25 || f == 6'h20 || f == 6'h22 || f == 6'h2A)
          f = 6'($urandom_range(0, 63));
      end else begin
        f = legal_f[$urandom_range(0, 4)];
      end
      a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
      accept(f, a, b, 1'b0, 6'd0, 32'd0, 32'd0);
      complete(f, a, b, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CNT_MAX + 1; i++) begin
      accept(6'h20, 32'(i), 32'd3, 1'b0, 6'd0, 32'd0, 32'd0);
      complete(6'h20, 32'(i), 32'd3, 0);
    end
    checks++;
    if (op_count !== CNT_W'(CNT_MAX)) begin
      errors++;
      $display("FAIL op_count_saturate: got %0d required %0d", op_count, CNT_MAX);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_illegal();
    test_back_to_back();
    test_reset_mid_exec();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
